dot_product_mac: RTL and testbench

Sequential dot-product engine that accepts a stream of unsigned 4-bit operand pairs over a valid/ready handshake. It performs one multiply-accumulate per accepted pair and emits one result after every N_TERMS pairs. It sits directly upstream of the chip output byte and replaces the fixed combinational 64-product adder tree with a time-multiplexed single multiplier. Its 8-bit low result equals that tree's output when all 64 operand pairs are equal.

---
 rtl/dot_product_mac_pkg.sv | 36 +++
 rtl/dot_product_mac_if.sv | 49 ++++
 rtl/dot_product_mac.sv | 154 +++++++++++++++
 tb/tb_dot_product_mac.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dot_product_mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg
//   Shared constants and helpers for the dot-product MAC slice.
//   - OPND_W / PROD_W : operand and product widths (4x4 -> 8 bit)
//   - MAX_PROD        : largest single product, 15*15
//   - CNT_W           : width of the per-block term counter
//   - mac_phase_e     : implicit control phase derived from the term counter
//   - acc_width(n)    : minimum accumulator width able to hold n max products
// ----------------------------------------------------------------------------
package mac_pkg;

  localparam int OPND_W   = 4;
  localparam int PROD_W   = 8;
  localparam int MAX_PROD = 225;
  localparam int CNT_W    = 10;
  localparam int LOW_W    = 8;

  // ACCUM: more terms to come in this block; FINAL: the next accept closes it.
  typedef enum logic [0:0] {
    PH_ACCUM = 1'b0,
    PH_FINAL = 1'b1
  } mac_phase_e;

  // Smallest w with 2^w > n*MAX_PROD, i.e. ceil(log2(n*MAX_PROD + 1)).
  function automatic int acc_width(input int n);
    longint max_sum;
    int     w;
    max_sum = longint'(n) * longint'(MAX_PROD);
    w       = 0;
    while ((longint'(1) << w) <= max_sum) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dot_product_mac_if.sv
// ----------------------------------------------------------------------------
// dot_product_mac_if
//   Operand-in / result-out handshake bundle of the dot-product MAC.
//   Signals:
//     in_valid, in_a, in_b  : operand pair offered by the producer
//     in_ready              : MAC accepts the pair this cycle
//     out_valid, out_sum,
//     out_low               : result held by the MAC
//     out_ready             : consumer takes the result this cycle
//   Modports:
//     master : producer/consumer side (testbench or upstream logic)
//     slave  : the MAC itself
// ----------------------------------------------------------------------------
interface dot_product_mac_if #(
  parameter int ACC_W = 14
);

  logic                        in_valid;
  logic                        in_ready;
  logic [mac_pkg::OPND_W-1:0]  in_a;
  logic [mac_pkg::OPND_W-1:0]  in_b;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_W-1:0]            out_sum;
  logic [mac_pkg::LOW_W-1:0]   out_low;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_low
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_low
  );

endinterface

// File: rtl/dot_product_mac.sv
// ----------------------------------------------------------------------------
// dot_product_mac
//   Time-multiplexed dot-product engine: one 4x4 multiply and one add per
//   accepted operand pair, one result per N_TERMS pairs. The result sits in a
//   one-entry output register so the next block keeps accumulating while a
//   result waits for the consumer.
//
//   Parameters:
//     N_TERMS : products per result, 1..1024
//     ACC_W   : accumulator/result width, >= acc_width(N_TERMS)
//   Ports:
//     clk      : clock, all state updates on the rising edge
//     rst      : synchronous active-high reset, highest priority
//     flush    : drop the partial accumulation (result register untouched)
//     bus      : operand/result handshake (slave side)
//     term_cnt : pairs accepted into the current block, 0..N_TERMS-1
// ----------------------------------------------------------------------------
module dot_product_mac
  import mac_pkg::*;
#(
  parameter int N_TERMS = 64,
  parameter int ACC_W   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  dot_product_mac_if.slave      bus,
  output logic [CNT_W-1:0]      term_cnt
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if ((N_TERMS < 1) || (N_TERMS > 1024)) begin : g_bad_n_terms
    $error("dot_product_mac: N_TERMS=%0d outside 1..1024", N_TERMS);
  end

  if (ACC_W < acc_width(N_TERMS)) begin : g_bad_acc_w
    $error("dot_product_mac: ACC_W=%0d too narrow, need %0d",
           ACC_W, acc_width(N_TERMS));
  end

  // Index of the term that closes a block.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

  // --------------------------------------------------------------------------
  // State and combinational signals
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0]  acc_q,       acc_d;
  logic [ACC_W-1:0]  res_q,       res_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              out_valid_q, out_valid_d;

  mac_phase_e        phase_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              consume_s;
  logic              load_s;
  logic [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]  sum_s;

  // Implicit control phase decoded from the term counter.
  always_comb begin
    if (cnt_q == LAST_IDX) begin
      phase_s = PH_FINAL;
    end else begin
      phase_s = PH_ACCUM;
    end
  end

  // Handshake decode. in_ready depends combinationally on out_ready so that a
  // waiting result can be replaced in the very cycle it is consumed.
  always_comb begin
    in_ready_s = !((phase_s == PH_FINAL) && out_valid_q && !bus.out_ready);
    accept_s   = bus.in_valid && in_ready_s;
    consume_s  = out_valid_q && bus.out_ready;
    // A flush drops the term even when it would have closed the block.
    load_s     = accept_s && !flush && (phase_s == PH_FINAL);
  end

  // Single multiplier and adder shared by every term.
  always_comb begin
    // 4x4 unsigned product always fits in 8 bits.
    prod_s = PROD_W'(bus.in_a) * PROD_W'(bus.in_b);
    sum_s  = acc_q + ACC_W'(prod_s);
  end

  // Next-state for accumulator, counter and result register.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept_s) begin
      case (phase_s)
        PH_ACCUM: begin
          acc_d = sum_s;
          cnt_d = cnt_q + CNT_W'(1);
        end
        PH_FINAL: begin
          res_d = sum_s;
          acc_d = '0;
          cnt_d = '0;
        end
        default: begin
          acc_d = acc_q;
          cnt_d = cnt_q;
        end
      endcase
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Result-valid flag: a new load wins over a same-cycle consume.
  always_comb begin
    out_valid_d = out_valid_q;
    if (load_s) begin
      out_valid_d = 1'b1;
    end else if (consume_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = res_q;
  assign bus.out_low   = res_q[LOW_W-1:0];
  assign term_cnt      = cnt_q;

endmodule

// File: tb/tb_dot_product_mac.sv
// ----------------------------------------------------------------------------
// tb_dot_product_mac
//   Self-checking bench for dot_product_mac (N_TERMS=64, ACC_W=14).
//   A reference model tracks the block as a list of products and the output
//   buffer as a pending flag plus value; every cycle the DUT is compared to it.
//   Table vectors and hand-written sequences add constant expectations.
// ----------------------------------------------------------------------------
module tb_dot_product_mac;

  localparam int N  = 64;
  localparam int AW = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [9:0] term_cnt;

  dot_product_mac_if #(.ACC_W(AW)) bus ();

  dot_product_mac #(
    .N_TERMS (N),
    .ACC_W   (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .term_cnt (term_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int unsigned m_terms[$];
  bit          m_pend;
  int unsigned m_result;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    int unsigned exp_sum;
    logic [7:0]  exp_low;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check state.
  task automatic cycle(input bit r, input bit fl, input bit v,
                       input logic [3:0] a, input logic [3:0] b, input bit ordy);
    bit          rdy_m;
    int unsigned s;
    rst           = r;
    flush         = fl;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    #1;
    rdy_m = !((m_terms.size() == N - 1) && m_pend && !ordy);
    if (!r) chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy_m});
    @(posedge clk);
    if (r) begin
      m_terms.delete();
      m_pend   = 1'b0;
      m_result = 0;
    end else begin
      if (m_pend && ordy) m_pend = 1'b0;
      if (fl) begin
        m_terms.delete();
      end else if (v && rdy_m) begin
        m_terms.push_back(int'(a) * int'(b));
        if (m_terms.size() == N) begin
          s = 0;
          foreach (m_terms[i]) s += m_terms[i];
          m_result = s % (1 << AW);
          m_pend   = 1'b1;
          m_terms.delete();
        end
      end
    end
    #1;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_pend});
    chk("out_sum",   32'(bus.out_sum), m_result);
    chk("out_low",   32'(bus.out_low), m_result & 32'd255);
    chk("term_cnt",  32'(term_cnt), m_terms.size());
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = 4'd0; bus.in_b = 4'd0; bus.out_ready = 1'b0;
    m_pend = 1'b0; m_result = 0;

    // Reset and reset-state checks
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_sum",   32'(bus.out_sum), 32'd0);
    chk("rst_out_low",   32'(bus.out_low), 32'd0);
    chk("rst_term_cnt",  32'(term_cnt), 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);

    // Table-driven uniform blocks, out_ready held high
    vecs[0] = '{4'd15, 4'd15, 32'd14400, 8'h40};
    vecs[1] = '{4'd3,  4'd5,  32'd960,   8'hC0};
    vecs[2] = '{4'd1,  4'd1,  32'd64,    8'h40};
    vecs[3] = '{4'd0,  4'd9,  32'd0,     8'h00};
    vecs[4] = '{4'd15, 4'd1,  32'd960,   8'hC0};
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) begin
        cycle(1'b0, 1'b0, 1'b1, vecs[k].a, vecs[k].b, 1'b1);
        if (i == N - 2) chk("vec_no_early_valid", {31'd0, bus.out_valid}, 32'd0);
      end
      chk("vec_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("vec_sum",   32'(bus.out_sum), vecs[k].exp_sum);
      chk("vec_low",   32'(bus.out_low), 32'(vecs[k].exp_low));
      cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
      chk("vec_single_pulse", {31'd0, bus.out_valid}, 32'd0);
    end

    // Backpressure: 128 pairs of (1,2) with out_ready low
    for (int i = 0; i < 127; i++) cycle(1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
      chk("bp_stall_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_stall_cnt",   32'(term_cnt), 32'd63);
      chk("bp_held_sum",    32'(bus.out_sum), 32'd128);
    end
    cycle(1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 1'b1);
    chk("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_second_sum",   32'(bus.out_sum), 32'd128);
    chk("bp_cnt_wrap",     32'(term_cnt), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

    // Simultaneous consume and final accept
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 1'b0);
    chk("sim_first_sum", 32'(bus.out_sum), 32'd384);
    for (int i = 0; i < N - 1; i++) cycle(1'b0, 1'b0, 1'b1, 4'd4, 4'd4, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4'd4, 4'd4, 1'b1);
    chk("sim_valid_kept", {31'd0, bus.out_valid}, 32'd1);
    chk("sim_second_sum", 32'(bus.out_sum), 32'd1024);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);

    // Flush with a same-cycle valid pair
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b1);
    chk("fl_cnt_before", 32'(term_cnt), 32'd10);
    cycle(1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 1'b1);
    chk("fl_cnt_cleared", 32'(term_cnt), 32'd0);
    chk("fl_result_kept", 32'(bus.out_sum), 32'd1024);
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b1);
    chk("fl_result", 32'(bus.out_sum), 32'd64);
    chk("fl_valid",  {31'd0, bus.out_valid}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);

    // Reset mid-block with a pending result
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 1'b0);
    chk("rm_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rm_cnt",   32'(term_cnt), 32'd0);
    chk("rm_sum",   32'(bus.out_sum), 32'd0);
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 1'b1);
    chk("rm_result", 32'(bus.out_sum), 32'd192);
    chk("rm_low",    32'(bus.out_low), 32'd192);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 799) == 0),
            ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0));
    end
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
